// File: rtl/fetch_pc_unit.sv
// F-stage fetch unit: owns the program counter, drives the instruction-memory
// address and forms the F-stage bundle (instruction, PC, ExcCode, delay-slot flag).
module fetch_pc_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI   = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        req,
    input  logic        d_eret,
    input  logic [31:0] epc,
    input  logic        d_redirect,
    input  logic [31:0] d_target,
    input  logic        d_is_bj,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_Instr,
    output logic [31:0] F_PC,
    output logic [4:0]  F_ExcCode,
    output logic        F_BD
);

    logic [31:0] r_pc;
    logic        w_bad;

    // Targets are never validated here; a bad PC is flagged when it is fetched.
    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= PC_INIT;
        else if (req)
            r_pc <= EXC_ENTRY;
        else if (!en)
            r_pc <= r_pc;
        else if (d_eret)
            r_pc <= epc;
        else if (d_redirect)
            r_pc <= d_target;
        else
            r_pc <= r_pc + 32'd4;
    end

    assign w_bad = (r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI);

    assign i_inst_addr = r_pc;
    assign F_PC        = r_pc;
    assign F_ExcCode   = w_bad ? EXC_ADEL : 5'd0;
    assign F_Instr     = (w_bad || d_eret) ? 32'd0 : i_inst_rdata;
    // eret has no delay slot, so the instruction behind it is never a BD slot.
    assign F_BD        = d_is_bj && !d_eret;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: walks reset, free-run, redirect, stall,
// exception, eret, AdEL boundaries and priority cases against hand-computed values.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset, en, req, d_eret, d_redirect, d_is_bj;
    logic [31:0] epc, d_target;
    logic [31:0] i_inst_addr, i_inst_rdata, F_Instr, F_PC;
    logic [4:0]  F_ExcCode;
    logic        F_BD;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: word content is a fixed scramble of its address.
    assign i_inst_rdata = i_inst_addr ^ 32'hA5A5_0000;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .d_eret(d_eret), .epc(epc),
        .d_redirect(d_redirect), .d_target(d_target), .d_is_bj(d_is_bj),
        .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
        .F_Instr(F_Instr), .F_PC(F_PC), .F_ExcCode(F_ExcCode), .F_BD(F_BD)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Full bundle check for a PC whose instruction is expected to pass through.
    task automatic check_ok(input string tag, input logic [31:0] pc, input logic bd);
        check({tag, " pc"},    F_PC, pc);
        check({tag, " addr"},  i_inst_addr, pc);
        check({tag, " exc"},   {27'd0, F_ExcCode}, 32'd0);
        check({tag, " instr"}, F_Instr, pc ^ 32'hA5A5_0000);
        check({tag, " bd"},    {31'd0, F_BD}, {31'd0, bd});
    endtask

    task automatic check_bad(input string tag, input logic [31:0] pc);
        check({tag, " pc"},    F_PC, pc);
        check({tag, " exc"},   {27'd0, F_ExcCode}, 32'd4);
        check({tag, " instr"}, F_Instr, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; req = 1'b0; d_eret = 1'b0; d_redirect = 1'b0;
        d_is_bj = 1'b0; epc = 32'd0; d_target = 32'd0;
        step();
        reset = 1'b0;
        #1;
        check_ok("reset", 32'h3000, 1'b0);
        step(); check_ok("run1", 32'h3004, 1'b0);
        step(); check_ok("run2", 32'h3008, 1'b0);
        step(); check_ok("run3", 32'h300C, 1'b0);
        step(); check_ok("run4", 32'h3010, 1'b0);

        // Taken branch at 3010
        d_is_bj = 1'b1; d_redirect = 1'b1; d_target = 32'h3400;
        #1; check_ok("br_bd", 32'h3010, 1'b1);
        step();
        d_is_bj = 1'b0; d_redirect = 1'b0;
        #1; check_ok("br_tgt", 32'h3400, 1'b0);

        // Jump to 3020, then stall there
        d_redirect = 1'b1; d_target = 32'h3020;
        step();
        d_redirect = 1'b0; en = 1'b0;
        #1; check_ok("stall0", 32'h3020, 1'b0);
        step(); check_ok("stall1", 32'h3020, 1'b0);
        d_is_bj = 1'b1;
        #1; check_ok("stall_bd", 32'h3020, 1'b1);
        step(); check_ok("stall2", 32'h3020, 1'b1);
        d_is_bj = 1'b0; d_redirect = 1'b1; d_target = 32'h5000;
        step(); check_ok("stall3", 32'h3020, 1'b0);
        d_redirect = 1'b0; req = 1'b1;
        step(); check_ok("req_stall", 32'h4180, 1'b0);
        req = 1'b0; en = 1'b1;

        // eret at 4200
        d_redirect = 1'b1; d_target = 32'h4200;
        step(); check_ok("to4200", 32'h4200, 1'b0);
        d_redirect = 1'b0; d_eret = 1'b1; epc = 32'h3024; d_is_bj = 1'b1;
        #1;
        check("eret instr", F_Instr, 32'd0);
        check("eret bd", {31'd0, F_BD}, 32'd0);
        check("eret exc", {27'd0, F_ExcCode}, 32'd0);
        step();
        d_eret = 1'b0; d_is_bj = 1'b0;
        #1; check_ok("eret_ret", 32'h3024, 1'b0);

        // Fetch-address boundaries
        d_redirect = 1'b1; d_target = 32'h3002;
        step(); check_bad("misalign", 32'h3002);
        d_redirect = 1'b0;
        step(); check_bad("bad_adv", 32'h3006);
        d_redirect = 1'b1; d_target = 32'h7000;
        step(); check_bad("above_hi", 32'h7000);
        d_target = 32'h6FFC;
        step(); check_ok("at_hi", 32'h6FFC, 1'b0);
        d_redirect = 1'b0;
        step(); check_bad("hi_plus4", 32'h7000);
        d_redirect = 1'b1; d_target = 32'h2FFC;
        step(); check_bad("below_lo", 32'h2FFC);
        d_target = 32'hFFFF_FFFC;
        step(); check_bad("top", 32'hFFFF_FFFC);
        d_redirect = 1'b0;
        step(); check_bad("wrap", 32'h0000_0000);

        // Priority cases
        d_eret = 1'b1; epc = 32'h3100; d_redirect = 1'b1; d_target = 32'h3200;
        step(); check("eret_over_br", F_PC, 32'h3100);
        req = 1'b1;
        step(); check("req_wins", F_PC, 32'h4180);
        d_eret = 1'b0; d_redirect = 1'b0; reset = 1'b1;
        step(); check("reset_wins", F_PC, 32'h3000);
        reset = 1'b0; req = 1'b0;
        step(); check_ok("post_reset", 32'h3004, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

F-stage fetch unit for the five-stage MIPS pipeline. It owns the program counter, drives the instruction-memory address, and produces the F-stage bundle consumed by the F/D pipeline register: instruction, PC, fetch exception code and branch-delay flag. It resolves next-PC priority among exception entry, `eret` return, D-stage branch/jump redirect, stall hold and sequential increment. It sits between the instruction memory and the F/D register.

## Interface
- `PC_INIT`, 32'h0000_3000, PC value after reset.
- `EXC_ENTRY`, 32'h0000_4180, handler entry PC loaded on `req`.
- `TEXT_LO`, 32'h0000_3000, lowest legal fetch address (inclusive).
- `TEXT_HI`, 32'h0000_6FFC, highest legal fetch address (inclusive).
- `EXC_ADEL`, 5'd4, ExcCode reported for an illegal fetch.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  1 = F may advance; 0 = stall, hold PC.
- `req`  in  1  exception/interrupt taken this cycle (from CP0).
- `d_eret`  in  1  D-stage instruction is `eret`.
- `epc`  in  32  return address from CP0.
- `d_redirect`  in  1  D-stage branch taken or jump.
- `d_target`  in  32  D-stage redirect target.
- `d_is_bj`  in  1  D-stage instruction is any branch/jump (taken or not).
- `i_inst_addr`  out  32  instruction-memory address (= `F_PC`).
- `i_inst_rdata`  in  32  instruction word, combinational read.
- `F_Instr`  out  32  fetched instruction, or 0 when suppressed.
- `F_PC`  out  32  current PC register.
- `F_ExcCode`  out  5  0 or `EXC_ADEL`.
- `F_BD`  out  1  F instruction sits in a delay slot.

## Operation
- Single state register `pc` (32 bits); `F_PC = i_inst_addr = pc`.
- Fetch check, combinational: `bad = (pc[1:0] != 0) || pc < TEXT_LO || pc > TEXT_HI` (unsigned compare).
- `F_ExcCode = bad ? EXC_ADEL : 0`.
- `F_Instr = 0` if `bad` or `d_eret`; else `i_inst_rdata`.
- `F_BD = d_is_bj`, regardless of `bad`. Forced to 0 when `d_eret`, because `eret` has no delay slot.
- Next-PC priority, evaluated on each rising edge:
  1. `reset` → `PC_INIT`.
  2. `req` → `EXC_ENTRY`, ignoring `en`.
  3. `!en` → hold `pc`.
  4. `d_eret` → `epc`.
  5. `d_redirect` → `d_target`.
  6. Otherwise → `pc + 4`, modulo 2^32, no trap on wrap.
- No target validation at redirect time. A misaligned or out-of-range `epc`/`d_target` is loaded as-is and flagged as AdEL in the following F cycle.
- A faulting PC still advances (+4 or redirect) when `en = 1`. Killing the flow is CP0's job via `req`.

## Timing
- Reset values: `pc = PC_INIT`, so `F_PC = 32'h3000`, `F_ExcCode = 0`, `F_BD = d_is_bj`, `F_Instr = i_inst_rdata` at 0x3000.
- Outputs are combinational from `pc` and D-stage inputs. There is zero added latency from `pc` to the bundle.
- Redirect latency is 1 cycle: a target sampled at edge N appears on `F_PC` after edge N.
- `req` with `en = 0` → PC goes to `EXC_ENTRY` anyway. `req` with `d_eret` or `d_redirect` → `req` wins.
- `d_eret` and `d_redirect` both high → `eret` wins; the decoder must never assert both.
- Stall held for k cycles → `pc` is unchanged for k edges, and outputs track any change on D-stage inputs.
- `reset` mid-stall or mid-redirect → `PC_INIT` on that edge.

## Test plan
- Reset then 3 free-run cycles with `en = 1` → `F_PC` goes 3000, 3004, 3008, 300C. `F_ExcCode = 0` and `F_BD = 0` throughout.
- At `pc = 3010`, set `d_is_bj = 1`, `d_redirect = 1`, `d_target = 3400` for 1 cycle → `F_BD = 1` at 3010, next `F_PC = 3400`, and `F_BD = 0` once `d_is_bj` drops.
- Hold `en = 0` for 3 cycles at 3020 → `F_PC` stays 3020. Pulse `req` during the stall → next `F_PC = 4180`.
- At 4200, set `d_eret = 1`, `epc = 3024` → `F_Instr = 0` and `F_BD = 0` that cycle, next `F_PC = 3024`.
- Drive `d_target = 3002` → next cycle shows `F_PC = 3002`, `F_ExcCode = 4`, `F_Instr = 0`. Repeat with `d_target = 7000` → `F_ExcCode = 4`. Repeat with `d_target = 6FFC` → `F_ExcCode = 0`.
- Assert `req`, `d_eret` and `d_redirect` together → next `F_PC = 4180`. Assert `reset` and `req` together → next `F_PC = 3000`.
